// File: rtl/red_barrett_pipe_if.sv
// Operand/result stream bundle for red_barrett_pipe: valid/ready on both sides plus sideband tag.
// Signal names keep the block's port naming; the slave modport is the multiplier's view.
interface red_barrett_pipe_if #(
  parameter int unsigned QW    = 23,
  parameter int unsigned TAG_W = 4
);
  logic             valid_i;
  logic             ready_o;
  logic [QW-1:0]    a_i;
  logic [QW-1:0]    b_i;
  logic [TAG_W-1:0] tag_i;
  logic             valid_o;
  logic             ready_i;
  logic [QW-1:0]    result_o;
  logic [TAG_W-1:0] tag_o;
  logic             busy_o;

  modport master (
    output valid_i, a_i, b_i, tag_i, ready_i,
    input  ready_o, valid_o, result_o, tag_o, busy_o
  );

  modport slave (
    input  valid_i, a_i, b_i, tag_i, ready_i,
    output ready_o, valid_o, result_o, tag_o, busy_o
  );
endinterface

// File: rtl/red_barrett_pipe.sv
// Three-stage pipelined (a*b) mod Q via Barrett reduction with valid/ready handshake and tag.
// All stages advance together on en; a stalled output freezes the whole pipe, bubbles included.
module red_barrett_pipe #(
  parameter int unsigned QW    = 23,
  parameter int unsigned Q     = 8380417,
  parameter int unsigned K     = 46,
  parameter int unsigned M     = 8396807,
  parameter int unsigned TAG_W = 4
) (
  input logic               clk_i,
  input logic               rst_ni,
  red_barrett_pipe_if.slave bus
);

  localparam int unsigned XW = 2 * QW;
  localparam int unsigned PW = 3 * QW + 1;
  localparam int unsigned RW = QW + 2;
  localparam longint unsigned MExp = (64'd1 << K) / 64'(Q);
  localparam logic [RW-1:0] QR = RW'(Q);

  if (64'(M) != MExp || K != 2 * QW || TAG_W < 1) begin : g_param_chk
    $error("red_barrett_pipe: need M == floor(2^K/Q), K == 2*QW and TAG_W >= 1");
  end

  logic             en;
  logic             v1_q, v2_q, v3_q;
  logic [XW-1:0]    x1_q, x1_d;
  logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q;
  logic [RW-1:0]    x2_q, x2_d;
  logic [QW:0]      t2_q, t2_d;
  logic [QW-1:0]    res_q, res_d;
  logic [RW-1:0]    tq, r0, r1;
  logic [RW:0]      d1, d2;
  logic             unused_hi;

  assign en          = !v3_q || bus.ready_i;
  assign bus.ready_o = en;
  assign bus.valid_o = v3_q;
  assign bus.result_o = res_q;
  assign bus.tag_o   = tag3_q;
  assign bus.busy_o  = v1_q || v2_q || v3_q;

  always_comb begin
    x1_d = XW'(bus.a_i) * XW'(bus.b_i);
    // Quotient estimate; t <= floor(x/Q) and x - t*Q < 3Q.
    t2_d = (QW + 1)'((PW'(x1_q) * PW'(M)) >> K);
    x2_d = RW'(x1_q);
    // Remainder only needs the low QW+2 bits since it is known to be below 3Q.
    tq = RW'(t2_q) * QR;
    r0 = x2_q - tq;
    d1 = {1'b0, r0} - {1'b0, QR};
    r1 = d1[RW] ? r0 : d1[RW-1:0];
    d2 = {1'b0, r1} - {1'b0, QR};
    res_d = d2[RW] ? r1[QW-1:0] : d2[QW-1:0];
  end

  assign unused_hi = ^{d2[RW-1:QW], r1[RW-1:QW]};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      x1_q   <= '0;
      x2_q   <= '0;
      t2_q   <= '0;
      res_q  <= '0;
      tag1_q <= '0;
      tag2_q <= '0;
      tag3_q <= '0;
    end else if (en) begin
      v1_q <= bus.valid_i;
      v2_q <= v1_q;
      v3_q <= v2_q;
      // Data registers load only behind a valid bit so outputs hold across bubbles.
      if (bus.valid_i) begin
        x1_q   <= x1_d;
        tag1_q <= bus.tag_i;
      end
      if (v1_q) begin
        x2_q   <= x2_d;
        t2_q   <= t2_d;
        tag2_q <= tag1_q;
      end
      if (v2_q) begin
        res_q  <= res_d;
        tag3_q <= tag2_q;
      end
    end
  end

endmodule

// File: doc/red_barrett_pipe.md
Name: red_barrett_pipe

Overview:
- Pipelined modular multiplier computing (a_i * b_i) mod Q by Barrett reduction.
- Generalised successor of the fixed-modulus combinational Dilithium reducer: modulus, width and Barrett constant are parameters.
- Includes the operand multiply, valid/ready handshake, backpressure and a sideband tag.
- Sits between NTT/pointwise datapath producers and coefficient storage. One instance is used per modulus; the Dilithium and Kyber configurations are both required.

Parameters:
- QW, 23, modulus and operand width in bits.
- Q, 8380417, modulus; requires 2^(QW-1) < Q < 2^QW.
- K, 46, Barrett shift; fixed to 2*QW.
- M, 8396807, Barrett multiplier; equals floor(2^K / Q). Kyber set: QW=12, Q=3329, K=24, M=5039.
- TAG_W, 4, sideband tag width; minimum 1.

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  synchronous active-low reset
- valid_i  in  1  input operands valid
- ready_o  out  1  block accepts input this cycle
- a_i  in  QW  operand a, any value 0..2^QW-1
- b_i  in  QW  operand b, any value 0..2^QW-1
- tag_i  in  TAG_W  sideband carried with the operands
- valid_o  out  1  result valid
- ready_i  in  1  downstream accepts result
- result_o  out  QW  (a*b) mod Q, always in 0..Q-1
- tag_o  out  TAG_W  tag of the result
- busy_o  out  1  any pipeline stage holds valid data

Behaviour:
- Clock and reset: single clock clk_i. Reset is synchronous, active-low on rst_ni.
- Reset values: all stage valid bits 0, so valid_o=0 and busy_o=0. result_o=0, tag_o=0, internal data registers 0.
- Reset mid-operation: in-flight data is discarded; no result emerges afterwards.
- Pipeline enable: en = !valid_o || ready_i. ready_o = en, combinational; no dependency on valid_i.
- Transfer rules: input transfer when valid_i && ready_o. Output transfer when valid_o && ready_i.
- Stage S1 (on en): x = a_i*b_i, 2*QW bits, unsigned; capture tag and valid (v1 = valid_i).
- Stage S2 (on en): t = (x*M) >> K, QW+1 bits; pass x, tag and v1 forward.
- Stage S3 (on en):
  - r = x - t*Q, computed in QW+2 bits.
  - Bound: r < 3Q for every x < 2^K.
  - Apply two sequential conditional subtractions of Q, each implemented as a borrow-select subtract.
  - Register the final value to result_o and tag_o; valid_o = v2.
- When en=0, all stages hold, including bubbles. Bubbles are not compressed.
- Latency: 3 cycles from input acceptance to valid_o with ready_i held high. Throughput: 1 result per cycle.
- Backpressure: while valid_o=1 and ready_i=0, result_o, tag_o and valid_o stay stable and no input is accepted. Deasserting ready_i for N cycles delays every in-flight result by exactly N cycles.
- Simultaneous events: an output transfer and an input transfer in the same cycle are legal and lose no data.
- Result values:
  - Exact for all operand pairs, including operands >= Q.
  - result_o is never >= Q.
  - Stage valid bits clear when a bubble advances, so result_o holds its last value while valid_o=0.
- busy_o = v1 || v2 || valid_o.
- Elaboration check: an assertion fires if M != floor(2^K/Q) or K != 2*QW.

Test Plan:
- Dilithium latency: reset, then a_i=8380416, b_i=8380416, tag=5 -> after 3 cycles valid_o=1, result_o=1, tag_o=5. busy_o falls the cycle after the transfer.
- Dilithium over-range operands: a_i=b_i=8388607 -> result_o=32764. Also a_i=0, b_i=8388607 -> result_o=0.
- Kyber config (QW=12, Q=3329, M=5039): a_i=b_i=3328 -> 1; a_i=b_i=4095 -> 852.
- Stream with backpressure: 8 back-to-back inputs (tags 0..7), ready_i low for 4 cycles starting cycle 4 -> outputs in order, no loss or duplication, each value matches a software model, ready_o low exactly while stalled.
- Reset mid-stream: 2 operations in flight, assert rst_ni=0 for one cycle -> valid_o=0 and busy_o=0 next cycle, no stale result ever appears.
- Random regression: 100k random operand pairs per config with random ready_i -> result_o == (a*b)%Q every transfer and result_o < Q always.
